// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the shared delay-timer arbiter.
// rr_pick is sized for the largest supported requester count.
package timer_arb_pkg;

  localparam int unsigned MaxReq  = 8;
  localparam int unsigned MaxIdxW = 3;
  localparam int unsigned MaxSumW = MaxIdxW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  // First set bit of req at or above ptr, wrapping at num; 0 when req is empty.
  function automatic logic [MaxIdxW-1:0] rr_pick(input logic [MaxReq-1:0]  req,
                                                 input logic [MaxIdxW-1:0] ptr,
                                                 input int unsigned        num);
    logic [MaxIdxW-1:0] win;
    logic               found;
    logic [MaxSumW-1:0] s;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      s = {1'b0, ptr} + MaxSumW'(i);
      if (s >= MaxSumW'(num)) s = s - MaxSumW'(num);
      if (!found && (i < num) && req[s[MaxIdxW-1:0]]) begin
        win   = s[MaxIdxW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick enable every TICK_CYCLES cycles.
// clr holds the counter at zero so a new delay always starts on a full tick period.
module tick_prescaler #(
  parameter int unsigned TICK_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || (cnt_q == CntMax)) cnt_d = '0;
  end

  assign tick = !clr && (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_arbiter.sv
// One shared millisecond delay timer, granted round-robin to NUM_REQ requesters.
// All outputs are registered; done pulses for the owner when its delay expires.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DLY_W   = 16,
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][DLY_W-1:0]   dly,
  input  logic                            abort,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      owner
);

  localparam int unsigned IdxW       = $clog2(NUM_REQ);
  localparam int unsigned TickCycles = CLK_HZ / TICK_HZ;

  state_t             state_q, state_d;
  logic [DLY_W-1:0]   count_q, count_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic [IdxW-1:0]    winner;
  logic [IdxW-1:0]    ptr_next;
  logic               tick;

  tick_prescaler #(
    .TICK_CYCLES(TickCycles)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (state_q != StRun),
    .tick(tick)
  );

  assign winner   = IdxW'(rr_pick(MaxReq'(req), MaxIdxW'(ptr_q), NUM_REQ));
  assign ptr_next = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    done_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          count_d         = dly[winner];
          owner_d         = winner;
          grant_d[winner] = 1'b1;
          state_d         = StRun;
        end
      end
      StRun: begin
        // Abort beats a coincident final tick.
        if (abort) begin
          ptr_d   = ptr_next;
          state_d = StIdle;
        end else if (count_q == '0) begin
          done_d[owner_q] = 1'b1;
          state_d         = StDone;
        end else if (tick) begin
          count_d = count_q - DLY_W'(1);
          if (count_q == DLY_W'(1)) begin
            done_d[owner_q] = 1'b1;
            state_d         = StDone;
          end
        end
      end
      StDone: begin
        ptr_d   = ptr_next;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with TICK_CYCLES=4; outputs sampled on negedge,
// inputs driven on negedge so each negedge after a drive is one cycle later.
module tb_timer_arbiter;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  logic [3:0][7:0] dly;
  logic            abort;
  logic [3:0]      grant;
  logic [3:0]      done;
  logic            busy;
  logic [1:0]      owner;

  int errors = 0;
  int checks = 0;

  timer_arbiter #(
    .NUM_REQ(4),
    .DLY_W  (8),
    .CLK_HZ (8),
    .TICK_HZ(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .dly  (dly),
    .abort(abort),
    .grant(grant),
    .done (done),
    .busy (busy),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, ".grant"}, 32'(grant), 0);
    check({tag, ".done"},  32'(done),  0);
    check({tag, ".busy"},  32'(busy),  0);
    check({tag, ".owner"}, 32'(owner), 0);
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    dly   = '0;
    abort = 1'b0;

    // 1. Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outs("reset");
    end
    rst = 1'b0;

    // 2. Single request, delay 3; dly changed after grant must be ignored.
    req    = 4'b0001;
    dly[0] = 8'd3;
    @(negedge clk);
    check("single.grant", 32'(grant), 1);
    check("single.busy_g", 32'(busy), 1);
    check("single.owner", 32'(owner), 0);
    req    = '0;
    dly[0] = 8'd1;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      check("single.no_early_done", 32'(done), 0);
    end
    @(negedge clk);
    check("single.done", 32'(done), 1);
    check("single.busy_done", 32'(busy), 1);
    @(negedge clk);
    check("single.busy_after", 32'(busy), 0);
    check("single.done_after", 32'(done), 0);

    // Reset pointer back to 0 for the fairness sequence.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // 3. Round-robin with all four requesting, delay 1 each.
    req = 4'b1111;
    for (int r = 0; r < 4; r++) dly[r] = 8'd1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      check("rr.grant", 32'(grant), 32'(1) << r);
      check("rr.owner", 32'(owner), r);
      req[r] = 1'b0;
      repeat (3) @(negedge clk);
      check("rr.no_early_done", 32'(done), 0);
      @(negedge clk);
      check("rr.done", 32'(done), 32'(1) << r);
      @(negedge clk);
      check("rr.idle_gap", 32'(busy), 0);
    end

    // 4. Zero delay: done one cycle after grant.
    req    = 4'b0100;
    dly[2] = 8'd0;
    @(negedge clk);
    check("zero.grant", 32'(grant), 4);
    req = '0;
    @(negedge clk);
    check("zero.done", 32'(done), 4);
    @(negedge clk);
    check("zero.busy_after", 32'(busy), 0);

    // 5. Abort during RUN, then pointer moved past owner 1.
    req    = 4'b0010;
    dly[1] = 8'd5;
    @(negedge clk);
    check("abort.grant", 32'(grant), 2);
    req = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("abort.no_done_run", 32'(done), 0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.busy_low", 32'(busy), 0);
    check("abort.no_done", 32'(done), 0);
    check("abort.owner", 32'(owner), 1);
    req    = 4'b0011;
    dly[0] = 8'd0;
    dly[1] = 8'd0;
    @(negedge clk);
    check("abort.rr_grant0", 32'(grant), 1);
    req = 4'b0010;
    @(negedge clk);
    check("abort.rr_done0", 32'(done), 1);
    @(negedge clk);
    check("abort.rr_idle", 32'(grant), 0);
    @(negedge clk);
    check("abort.rr_grant1", 32'(grant), 2);
    req = '0;
    @(negedge clk);
    check("abort.rr_done1", 32'(done), 2);
    @(negedge clk);

    // 6. Abort coinciding with the final tick suppresses done.
    req    = 4'b1000;
    dly[3] = 8'd2;
    @(negedge clk);
    check("race.grant", 32'(grant), 8);
    req = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("race.no_done_run", 32'(done), 0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("race.no_done", 32'(done), 0);
    check("race.busy_low", 32'(busy), 0);
    @(negedge clk);
    check("race.no_late_done", 32'(done), 0);

    // Reset mid-RUN with owner 2.
    req    = 4'b0100;
    dly[2] = 8'd10;
    @(negedge clk);
    check("rstrun.grant", 32'(grant), 4);
    check("rstrun.owner", 32'(owner), 2);
    req = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outs("rstrun");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstrun.no_done", 32'(done), 0);
      check("rstrun.busy", 32'(busy), 0);
    end

    // Maximum delay counts the full range without wrapping.
    req    = 4'b0001;
    dly[0] = 8'd255;
    @(negedge clk);
    check("max.grant", 32'(grant), 1);
    req = '0;
    repeat (1018) @(negedge clk);
    @(negedge clk);
    check("max.no_early_done", 32'(done), 0);
    check("max.busy", 32'(busy), 1);
    @(negedge clk);
    check("max.done", 32'(done), 1);
    @(negedge clk);
    check("max.busy_after", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
